block_transfer_controller: RTL and testbench

//  Sequences one block-engine transaction: pops WPB words from the input fifo into

---
 rtl/block_transfer_controller.sv | 154 +++++++++++++++
 tb/tb_block_transfer_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/block_transfer_controller.sv
// block_transfer_controller: control-only sequencer for one block-engine transaction
// (fill assembler -> run engine -> load disassembler -> drain). Define BTC_TIMEOUT_EN for the RUN watchdog.
module block_transfer_controller #(
  parameter int WSIZE   = 32,
  parameter int BSIZE   = 128,
  parameter int WPB     = BSIZE / WSIZE,
  parameter int TIMEOUT = 1024
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic        in_fifo_empty,
  output logic        in_fifo_read_en,
  output logic        asm_word_ready,
  output logic        asm_hold,
  output logic        engine_start,
  input  logic        engine_done,
  output logic        dis_block_ready,
  input  logic        dis_pull_block,
  input  logic        dis_word_ready,
  output logic        dis_hold,
  input  logic        out_fifo_full,
  output logic        out_fifo_write_en,
  output logic        busy,
  output logic [15:0] blocks_done,
  output logic        error
);

  localparam int CW = $clog2(WPB) + 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WPB - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL   = 3'd1;
  localparam logic [2:0] S_SETTLE = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_LOAD   = 3'd4;
  localparam logic [2:0] S_DRAIN  = 3'd5;

  if (WPB < 1 || WPB * WSIZE != BSIZE || TIMEOUT < 2) begin : g_param_check
    $error("block_transfer_controller: inconsistent WSIZE/BSIZE/WPB/TIMEOUT");
  end

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] word_cnt_q, word_cnt_d;
  logic [15:0]   blocks_done_q, blocks_done_d;
  logic          asm_word_ready_q, asm_word_ready_d;
  logic          engine_start_q, engine_start_d;
  logic          timeout_hit;

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    state_d           = state_q;
    word_cnt_d        = word_cnt_q;
    blocks_done_d     = blocks_done_q;
    in_fifo_read_en   = 1'b0;
    out_fifo_write_en = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && !in_fifo_empty) begin
          state_d    = S_FILL;
          word_cnt_d = '0;
        end
      end
      S_FILL: begin
        in_fifo_read_en = !in_fifo_empty;
        if (!in_fifo_empty) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) state_d = S_SETTLE;
        end
      end
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (engine_done)      state_d = S_LOAD;
        else if (timeout_hit) state_d = S_IDLE;
      end
      S_LOAD: begin
        if (dis_pull_block) begin
          state_d    = S_DRAIN;
          word_cnt_d = '0;
        end
      end
      S_DRAIN: begin
        out_fifo_write_en = dis_word_ready && !out_fifo_full;
        if (dis_word_ready && !out_fifo_full) begin
          word_cnt_d = word_cnt_q + 1'b1;
          if (word_cnt_q == LAST_WORD) begin
            blocks_done_d = blocks_done_q + 16'd1;
            word_cnt_d    = '0;
            state_d       = (enable && !in_fifo_empty) ? S_FILL : S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Fifo read data appears one cycle after the pop, so the assembler strobe trails it.
  assign asm_word_ready_d = in_fifo_read_en;
  assign engine_start_d   = (state_d == S_RUN) && (state_q != S_RUN);

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q          <= S_IDLE;
      word_cnt_q       <= '0;
      blocks_done_q    <= '0;
      asm_word_ready_q <= 1'b0;
      engine_start_q   <= 1'b0;
    end else begin
      state_q          <= state_d;
      word_cnt_q       <= word_cnt_d;
      blocks_done_q    <= blocks_done_d;
      asm_word_ready_q <= asm_word_ready_d;
      engine_start_q   <= engine_start_d;
    end
  end

`ifdef BTC_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] timer_q, timer_d;
  logic          error_q, error_d;

  assign timeout_hit = (state_q == S_RUN) && !engine_done && (timer_q == TW'(TIMEOUT - 1));

  always_comb begin
    timer_d = (state_q == S_RUN) ? timer_q + 1'b1 : '0;
    error_d = error_q || timeout_hit;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      timer_q <= '0;
      error_q <= 1'b0;
    end else begin
      timer_q <= timer_d;
      error_q <= error_d;
    end
  end

  assign error = error_q;
`else
  assign timeout_hit = 1'b0;
  assign error       = 1'b0;
`endif

  assign asm_word_ready  = asm_word_ready_q;
  assign engine_start    = engine_start_q;
  assign asm_hold        = !((state_q == S_FILL) || (state_q == S_SETTLE));
  assign dis_block_ready = (state_q == S_LOAD);
  assign dis_hold        = !((state_q == S_DRAIN) && !out_fifo_full);
  assign busy            = (state_q != S_IDLE);
  assign blocks_done     = blocks_done_q;

endmodule

// File: tb/tb_block_transfer_controller.sv
// Directed bench for block_transfer_controller: a small fifo/engine environment plus one task per scenario.
module tb_block_transfer_controller;

  logic        clock = 1'b0;
  logic        reset, enable, in_fifo_empty, engine_done, dis_pull_block, dis_word_ready, out_fifo_full;
  logic        in_fifo_read_en, asm_word_ready, asm_hold, engine_start, dis_block_ready;
  logic        dis_hold, out_fifo_write_en, busy, error;
  logic [15:0] blocks_done;

  int checks = 0, fails = 0;
  // Stimulus knobs, written only by the main initial block.
  int pushed = 0, done_delay = 0, empty_trig = -1, full_trig = -1;
  // Observations, written only by the negedge monitor.
  int cyc = 0, pops = 0, writes = 0, starts = 0, loads = 0, asm_open = 0, dis_open = 0;
  int pop_cyc[64];
  int wr_cyc[64];
  int start_cyc = -100, done_at = -1, err_cyc = -1;
  int empty_from = -1, empty_to = -2, full_from = -1, full_to = -2;
  int viol_asm = 0, viol_in = 0, viol_out = 0;
  logic prev_rd = 1'b0, prev_err = 1'b0, prev_rst = 1'b1;

  always #5 clock = ~clock;

  block_transfer_controller #(.WSIZE(32), .BSIZE(128), .TIMEOUT(16)) dut (
    .clock(clock), .reset(reset), .enable(enable), .in_fifo_empty(in_fifo_empty),
    .in_fifo_read_en(in_fifo_read_en), .asm_word_ready(asm_word_ready), .asm_hold(asm_hold),
    .engine_start(engine_start), .engine_done(engine_done), .dis_block_ready(dis_block_ready),
    .dis_pull_block(dis_pull_block), .dis_word_ready(dis_word_ready), .dis_hold(dis_hold),
    .out_fifo_full(out_fifo_full), .out_fifo_write_en(out_fifo_write_en), .busy(busy),
    .blocks_done(blocks_done), .error(error)
  );

  // Environment: input fifo level, engine completion and output-fifo stalls, updated just after each edge.
  always @(posedge clock) begin
    #1;
    in_fifo_empty = (pushed - pops <= 0) || (cyc >= empty_from && cyc <= empty_to);
    engine_done   = (cyc == done_at);
    out_fifo_full = (cyc >= full_from && cyc <= full_to);
  end

  // Monitor: samples mid-cycle, records event cycles and protocol violations.
  always @(negedge clock) begin
    if (!reset && !prev_rst) begin
      if (asm_word_ready !== prev_rd) viol_asm++;
      if (!asm_hold) asm_open++;
      if (!dis_hold) dis_open++;
    end
    if (in_fifo_read_en && in_fifo_empty) viol_in++;
    if (out_fifo_full && (out_fifo_write_en || !dis_hold)) viol_out++;
    if (out_fifo_write_en && dis_hold) viol_out++;
    if (in_fifo_read_en) begin
      if (pops < 64) pop_cyc[pops] = cyc;
      pops++;
      if (pops == empty_trig) begin empty_from = cyc + 1; empty_to = cyc + 3; end
    end
    if (engine_start) begin
      starts++;
      start_cyc = cyc;
      done_at   = (done_delay > 0) ? cyc + done_delay : -1;
    end
    if (dis_block_ready) loads++;
    if (out_fifo_write_en) begin
      if (writes < 64) wr_cyc[writes] = cyc;
      writes++;
      if (writes == full_trig) begin full_from = cyc + 1; full_to = cyc + 3; end
    end
    if (error === 1'b1 && prev_err !== 1'b1) err_cyc = cyc;
    prev_err = error;
    prev_rd  = in_fifo_read_en;
    prev_rst = reset;
    cyc++;
  end

  task automatic sample();
    @(negedge clock);
    #1;
  endtask

  task automatic apply_reset();
    @(posedge clock);
    #1;
    reset = 1'b1; enable = 1'b0; done_delay = 0; empty_trig = -1; full_trig = -1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  function automatic bit cond_met(input int kind, input int target);
    case (kind)
      0:       return writes >= target;
      1:       return starts >= target;
      2:       return (blocks_done == 16'(target)) && !busy;
      default: return error === 1'b1;
    endcase
  endfunction

  task automatic wait_for(input int kind, input int target, input int budget, input string name);
    int n = 0;
    sample();
    while (!cond_met(kind, target) && n < budget) begin
      sample();
      n++;
    end
    checks++;
    if (!cond_met(kind, target)) begin
      fails++;
      $display("FAIL %s: condition not reached within %0d cycles (blocks_done=%0d busy=%b)", name, budget, blocks_done, busy);
    end
  endtask

  task automatic test_reset();
    logic [8:0] idle_vec;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    sample();
    idle_vec = {busy, in_fifo_read_en, asm_word_ready, asm_hold, engine_start, dis_block_ready, dis_hold, out_fifo_write_en, error};
    checks++;
    if (idle_vec !== 9'b000100100 || blocks_done !== 16'd0) begin
      fails++; $display("FAIL reset_held: outputs=%b blocks_done=%0d, want 000100100 and 0", idle_vec, blocks_done);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    sample();
    idle_vec = {busy, in_fifo_read_en, asm_word_ready, asm_hold, engine_start, dis_block_ready, dis_hold, out_fifo_write_en, error};
    checks++;
    if (idle_vec !== 9'b000100100) begin
      fails++; $display("FAIL reset_release: outputs=%b want 000100100", idle_vec);
    end
    // Reset from the middle of RUN must also land in IDLE.
    pushed += 4; done_delay = 0; enable = 1'b1;
    wait_for(1, starts + 1, 30, "reset_reach_run");
    apply_reset();
    sample();
    idle_vec = {busy, in_fifo_read_en, asm_word_ready, asm_hold, engine_start, dis_block_ready, dis_hold, out_fifo_write_en, error};
    checks++;
    if (idle_vec !== 9'b000100100 || blocks_done !== 16'd0) begin
      fails++; $display("FAIL reset_from_run: outputs=%b blocks_done=%0d, want 000100100 and 0", idle_vec, blocks_done);
    end
  endtask

  task automatic test_basic();
    int pb, wb, sb, lb, va, ao, dopen;
    apply_reset();
    pb = pops; wb = writes; sb = starts; lb = loads; va = viol_asm; ao = asm_open; dopen = dis_open;
    pushed += 4; done_delay = 5; enable = 1'b1;
    wait_for(2, 1, 60, "basic_complete");
    checks++; if (pops - pb !== 4) begin fails++; $display("FAIL basic_pops: got %0d want 4", pops - pb); end
    checks++; if (pop_cyc[pb+3] - pop_cyc[pb] !== 3) begin fails++; $display("FAIL basic_pop_span: got %0d want 3", pop_cyc[pb+3] - pop_cyc[pb]); end
    checks++; if (starts - sb !== 1) begin fails++; $display("FAIL basic_start_cycles: got %0d want 1", starts - sb); end
    checks++; if (start_cyc - pop_cyc[pb+3] !== 2) begin fails++; $display("FAIL basic_pop_to_start: got %0d want 2", start_cyc - pop_cyc[pb+3]); end
    checks++; if (wr_cyc[wb] - done_at !== 2) begin fails++; $display("FAIL basic_done_to_write: got %0d want 2", wr_cyc[wb] - done_at); end
    checks++; if (writes - wb !== 4) begin fails++; $display("FAIL basic_writes: got %0d want 4", writes - wb); end
    checks++; if (wr_cyc[wb+3] - wr_cyc[wb] !== 3) begin fails++; $display("FAIL basic_write_span: got %0d want 3", wr_cyc[wb+3] - wr_cyc[wb]); end
    checks++; if (loads - lb !== 1) begin fails++; $display("FAIL basic_load_cycles: got %0d want 1", loads - lb); end
    checks++; if (asm_open - ao !== 5) begin fails++; $display("FAIL basic_asm_hold_low: got %0d cycles want 5", asm_open - ao); end
    checks++; if (dis_open - dopen !== 4) begin fails++; $display("FAIL basic_dis_hold_low: got %0d cycles want 4", dis_open - dopen); end
    checks++; if (viol_asm - va !== 0) begin fails++; $display("FAIL basic_asm_word_ready: %0d cycles not one behind read_en, want 0", viol_asm - va); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL basic_error: got %b want 0", error); end
  endtask

  task automatic test_in_stall();
    int pb, sb, vi;
    apply_reset();
    pb = pops; sb = starts; vi = viol_in;
    pushed += 4; empty_trig = pb + 2; done_delay = 3; enable = 1'b1;
    wait_for(2, 1, 60, "in_stall_complete");
    checks++; if (pops - pb !== 4) begin fails++; $display("FAIL in_stall_pops: got %0d want 4", pops - pb); end
    checks++; if (pop_cyc[pb+2] - pop_cyc[pb+1] !== 4) begin fails++; $display("FAIL in_stall_gap: got %0d want 4", pop_cyc[pb+2] - pop_cyc[pb+1]); end
    checks++; if (viol_in - vi !== 0) begin fails++; $display("FAIL in_stall_read_while_empty: got %0d want 0", viol_in - vi); end
    checks++; if (starts - sb !== 1) begin fails++; $display("FAIL in_stall_reach_run: starts %0d want 1", starts - sb); end
    checks++; if (start_cyc - pop_cyc[pb+3] !== 2) begin fails++; $display("FAIL in_stall_pop_to_start: got %0d want 2", start_cyc - pop_cyc[pb+3]); end
  endtask

  task automatic test_out_stall();
    int wb, vo;
    apply_reset();
    wb = writes; vo = viol_out;
    pushed += 4; full_trig = wb + 1; done_delay = 1; enable = 1'b1;
    wait_for(2, 1, 60, "out_stall_complete");
    checks++; if (writes - wb !== 4) begin fails++; $display("FAIL out_stall_writes: got %0d want 4", writes - wb); end
    checks++; if (wr_cyc[wb+1] - wr_cyc[wb] !== 4) begin fails++; $display("FAIL out_stall_gap: got %0d want 4", wr_cyc[wb+1] - wr_cyc[wb]); end
    checks++; if (wr_cyc[wb+3] - wr_cyc[wb+1] !== 2) begin fails++; $display("FAIL out_stall_tail: got %0d want 2", wr_cyc[wb+3] - wr_cyc[wb+1]); end
    checks++; if (viol_out - vo !== 0) begin fails++; $display("FAIL out_stall_hold: got %0d bad cycles want 0", viol_out - vo); end
  endtask

  task automatic test_timeout();
    int sb, wb;
    apply_reset();
    sb = starts; wb = writes;
    pushed += 4; done_delay = 0; enable = 1'b1;
    wait_for(1, sb + 1, 30, "timeout_reach_run");
`ifdef BTC_TIMEOUT_EN
    wait_for(3, 0, 40, "timeout_error_rise");
    checks++; if (err_cyc - start_cyc !== 16) begin fails++; $display("FAIL timeout_latency: got %0d want 16", err_cyc - start_cyc); end
    checks++; if (busy !== 1'b0 || blocks_done !== 16'd0) begin fails++; $display("FAIL timeout_idle: busy=%b blocks_done=%0d want 0 0", busy, blocks_done); end
    repeat (5) sample();
    checks++; if (error !== 1'b1) begin fails++; $display("FAIL timeout_sticky: got %b want 1", error); end
`else
    repeat (40) sample();
    checks++; if (busy !== 1'b1 || dis_block_ready !== 1'b0) begin fails++; $display("FAIL timeout_still_run: busy=%b dis_block_ready=%b want 1 0", busy, dis_block_ready); end
    checks++; if (error !== 1'b0) begin fails++; $display("FAIL timeout_error_tied: got %b want 0", error); end
`endif
    checks++; if (writes - wb !== 0) begin fails++; $display("FAIL timeout_writes: got %0d want 0", writes - wb); end
    apply_reset();
    sample();
    checks++; if (error !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL timeout_reset_clear: error=%b busy=%b want 0 0", error, busy); end
  endtask

  task automatic test_reset_mid();
    int wb, pb;
    apply_reset();
    wb = writes; pb = pops;
    pushed += 4; done_delay = 2; enable = 1'b1;
    wait_for(0, wb + 2, 60, "mid_reach_2nd_write");
    reset = 1'b1;
    sample();
    checks++; if (busy !== 1'b0 || blocks_done !== 16'd0 || out_fifo_write_en !== 1'b0) begin
      fails++; $display("FAIL mid_reset_idle: busy=%b blocks_done=%0d write_en=%b want 0 0 0", busy, blocks_done, out_fifo_write_en);
    end
    @(posedge clock);
    #1 reset = 1'b0;
    repeat (4) sample();
    checks++; if (writes - wb !== 2) begin fails++; $display("FAIL mid_reset_no_more_writes: got %0d want 2", writes - wb); end
    pushed += 8;
    wait_for(2, 2, 150, "mid_two_blocks");
    checks++; if (writes - wb !== 10) begin fails++; $display("FAIL mid_total_writes: got %0d want 10", writes - wb); end
    checks++; if (pops - pb !== 12) begin fails++; $display("FAIL mid_total_pops: got %0d want 12", pops - pb); end
    checks++; if (pop_cyc[pb+8] - wr_cyc[wb+5] !== 1) begin fails++; $display("FAIL mid_back_to_back: got %0d want 1", pop_cyc[pb+8] - wr_cyc[wb+5]); end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; dis_pull_block = 1'b1; dis_word_ready = 1'b1;
    in_fifo_empty = 1'b1; engine_done = 1'b0; out_fifo_full = 1'b0;
    test_reset();
    test_basic();
    test_in_stall();
    test_out_stall();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
